// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size derivation, GF(2^8) helpers and FSM states.
// Imported by the key expander and its S-box datapath.
package aes_pkg;

  localparam logic [7:0] RconInit = 8'h01;

  localparam logic StIdle   = 1'b0;
  localparam logic StExpand = 1'b1;

  function automatic bit key_bits_legal(input int unsigned key_bits);
    return (key_bits == 128) || (key_bits == 192) || (key_bits == 256);
  endfunction

  function automatic int unsigned nk_of(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic int unsigned nw_of(input int unsigned key_bits);
    return 4 * (nr_of(key_bits) + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = prod x^(2^j), j = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int j = 1; j < 8; j++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_expander_if.sv
// Start/status/read-port bundle between the decryptor and the key expander.
interface key_expander_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                done;
  logic                key_ready;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_out;

  modport master (
    output start, key_in, rk_idx,
    input  busy, done, key_ready, rk_out
  );

  modport slave (
    input  start, key_in, rk_idx,
    output busy, done, key_ready, rk_out
  );
endinterface

// File: rtl/aes_sbox.sv
// Byte-wide AES forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel byte S-boxes over a 32-bit schedule word.
module aes_subword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  for (genvar b = 0; b < 4; b++) begin : gen_sbox
    aes_sbox u_sbox (
      .din  (word_in[8*b +: 8]),
      .dout (word_out[8*b +: 8])
    );
  end
endmodule

// File: rtl/key_expander.sv
// Sequential AES key expansion (one schedule word per cycle) with an indexed round-key store.
// Holds all Nr+1 round keys so the decryptor can read the last round key first.
module key_expander
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input logic          clk,
  input logic          rst,
  key_expander_if.slave bus
);
  localparam int unsigned Nk = nk_of(KEY_BITS);
  localparam int unsigned Nr = nr_of(KEY_BITS);
  localparam int unsigned NW = nw_of(KEY_BITS);
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned KW = $clog2(Nk);

  if (!key_bits_legal(KEY_BITS)) begin : gen_bad_key_bits
    $error("key_expander: KEY_BITS must be 128, 192 or 256");
  end

  logic           state_q;
  logic [IW-1:0]  i_q;
  logic [KW-1:0]  k_q;
  logic [7:0]     rcon_q;
  logic           busy_q;
  logic           done_q;
  logic           key_ready_q;
  logic [127:0]   rk_out_q;
  logic [31:0]    w_q [NW];

  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    temp;
  logic [31:0]    new_word;
  logic [5:0]     rk_base;

  // Both read taps are muxes on i; unused in IDLE, so their values there do not matter.
  assign w_prev = w_q[i_q - IW'(1)];
  assign w_back = w_q[i_q - IW'(Nk)];

  // RotWord is a byte rotation ahead of the single shared SubWord.
  assign sub_in = (k_q == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (k_q == '0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (Nk == 8 && int'(k_q) == 4) begin
      temp = sub_out;
    end
    new_word = w_back ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      k_q         <= '0;
      rcon_q      <= RconInit;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StExpand;
            i_q         <= IW'(Nk);
            k_q         <= '0;
            rcon_q      <= RconInit;
            busy_q      <= 1'b1;
            key_ready_q <= 1'b0;
          end
        end
        StExpand: begin
          i_q <= i_q + IW'(1);
          k_q <= (k_q == KW'(Nk - 1)) ? '0 : k_q + KW'(1);
          if (k_q == '0) rcon_q <= xtime(rcon_q);
          if (i_q == IW'(NW - 1)) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The word array is deliberately never cleared; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StIdle && bus.start) begin
        for (int j = 0; j < int'(Nk); j++) begin
          w_q[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
        end
      end else if (state_q == StExpand) begin
        w_q[i_q] <= new_word;
      end
    end
  end

  assign rk_base = {bus.rk_idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst || (32'(bus.rk_idx) > Nr)) begin
      rk_out_q <= '0;
    end else begin
      rk_out_q <= {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_ready = key_ready_q;
  assign bus.rk_out    = rk_out_q;
endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander: FIPS-197 schedules for all three key sizes, read-port
// boundaries, start-while-busy and reset behaviour.
module tb_key_expander;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  key_expander_if #(.KEY_BITS(128)) bus128 ();
  key_expander_if #(.KEY_BITS(192)) bus192 ();
  key_expander_if #(.KEY_BITS(256)) bus256 ();

  key_expander #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst(rst), .bus(bus128));
  key_expander #(.KEY_BITS(192)) u_dut192 (.clk(clk), .rst(rst), .bus(bus192));
  key_expander #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst(rst), .bus(bus256));

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk128 [11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int           busy_n [3];
    int           done_n [3];
    int           done_at [3];
    logic         prev_done;
    logic [127:0] post_done;
    int           waited;

    rk128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    bus128.start = 1'b0; bus128.key_in = '0; bus128.rk_idx = 4'd0;
    bus192.start = 1'b0; bus192.key_in = '0; bus192.rk_idx = 4'd0;
    bus256.start = 1'b0; bus256.key_in = '0; bus256.rk_idx = 4'd0;

    // Reset values, sampled while reset is still held.
    tick;
    tick;
    chk("reset_busy", 128'(bus128.busy), 128'd0);
    chk("reset_done", 128'(bus128.done), 128'd0);
    chk("reset_key_ready", 128'(bus256.key_ready), 128'd0);
    chk("reset_rk_out", bus192.rk_out, 128'd0);
    rst = 1'b0;

    // Launch all three key sizes together; re-start the 128-bit engine mid-run.
    bus128.key_in = K128; bus192.key_in = K192; bus256.key_in = K256;
    bus128.rk_idx = 4'd10;
    bus128.start = 1'b1; bus192.start = 1'b1; bus256.start = 1'b1;
    tick;
    bus128.start = 1'b0; bus192.start = 1'b0; bus256.start = 1'b0;
    for (int m = 0; m < 3; m++) begin
      busy_n[m] = 0; done_n[m] = 0; done_at[m] = -1;
    end
    prev_done = 1'b0;
    post_done = '0;
    for (int n = 0; n < 60; n++) begin
      if (bus128.busy) busy_n[0]++;
      if (bus192.busy) busy_n[1]++;
      if (bus256.busy) busy_n[2]++;
      if (bus128.done) begin done_n[0]++; done_at[0] = n; end
      if (bus192.done) begin done_n[1]++; done_at[1] = n; end
      if (bus256.done) begin done_n[2]++; done_at[2] = n; end
      if (prev_done) post_done = bus128.rk_out;
      prev_done = bus128.done;
      if (n == 10) begin
        bus128.start  = 1'b1;
        bus128.key_in = ~K128;
      end else begin
        bus128.start  = 1'b0;
      end
      tick;
    end
    chk("busy_cycles_128", 128'(busy_n[0]), 128'd40);
    chk("busy_cycles_192", 128'(busy_n[1]), 128'd46);
    chk("busy_cycles_256", 128'(busy_n[2]), 128'd52);
    chk("done_pulses_128", 128'(done_n[0]), 128'd1);
    chk("done_pulses_256", 128'(done_n[2]), 128'd1);
    chk("done_at_128", 128'(done_at[0]), 128'd40);
    chk("done_at_192", 128'(done_at[1]), 128'd46);
    chk("done_at_256", 128'(done_at[2]), 128'd52);
    chk("read_after_done_128", post_done, rk128[10]);
    chk("key_ready_128", 128'(bus128.key_ready), 128'd1);
    chk("key_ready_192", 128'(bus192.key_ready), 128'd1);
    chk("key_ready_256", 128'(bus256.key_ready), 128'd1);

    bus192.rk_idx = 4'd12;
    bus256.rk_idx = 4'd14;
    tick;
    chk("rk12_192", bus192.rk_out, 128'he98ba06f448c773c8ecc720401002202);
    chk("rk14_256", bus256.rk_out, 128'hfe4890d1e6188d0b046df344706c631e);
    bus192.rk_idx = 4'd0;
    bus256.rk_idx = 4'd0;
    tick;
    chk("rk0_192", bus192.rk_out, 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("rk0_256", bus256.rk_out, 128'h603deb1015ca71be2b73aef0857d7781);

    // Reverse sweep, one index per cycle.
    for (int r = 10; r >= 0; r--) begin
      bus128.rk_idx = 4'(r);
      tick;
      chk($sformatf("sweep_rk%0d_128", r), bus128.rk_out, rk128[r]);
    end
    bus128.rk_idx = 4'd11;
    tick;
    chk("rk11_128_out_of_range", bus128.rk_out, 128'd0);
    bus128.rk_idx = 4'd15;
    bus256.rk_idx = 4'd15;
    tick;
    chk("rk15_128_out_of_range", bus128.rk_out, 128'd0);
    chk("rk15_256_out_of_range", bus256.rk_out, 128'd0);

    // Reset 20 cycles into a run, with a simultaneous start that must lose.
    bus128.key_in = K128;
    bus128.start = 1'b1;
    tick;
    bus128.start = 1'b0;
    repeat (19) tick;
    chk("busy_before_reset", 128'(bus128.busy), 128'd1);
    rst = 1'b1;
    bus128.start = 1'b1;
    bus128.key_in = K0;
    tick;
    rst = 1'b0;
    bus128.start = 1'b0;
    chk("midrun_reset_busy", 128'(bus128.busy), 128'd0);
    chk("midrun_reset_done", 128'(bus128.done), 128'd0);
    chk("midrun_reset_key_ready", 128'(bus128.key_ready), 128'd0);
    chk("midrun_reset_key_ready_192", 128'(bus192.key_ready), 128'd0);
    chk("midrun_reset_rk_out", bus128.rk_out, 128'd0);
    tick;
    chk("reset_start_not_taken", 128'(bus128.busy), 128'd0);
    chk("key_ready_stays_low", 128'(bus128.key_ready), 128'd0);

    bus128.start = 1'b1;
    tick;
    bus128.start = 1'b0;
    waited = 0;
    while (!bus128.done && waited < 100) begin
      tick;
      waited++;
    end
    chk("k0_done_seen", 128'(bus128.done), 128'd1);
    bus128.rk_idx = 4'd10;
    tick;
    chk("k0_rk10", bus128.rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    bus128.rk_idx = 4'd0;
    tick;
    chk("k0_rk0", bus128.rk_out, K0);
    chk("k0_key_ready", 128'(bus128.key_ready), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/key_expander.md
# key_expander

Sequential AES key-expansion engine and round-key store, parametrised for 128/192/256-bit keys. It accepts a cipher key on a start handshake and generates one 32-bit schedule word per cycle through a shared SubWord/Rcon datapath. It holds all Nr+1 round keys in an internal word array, so the decryptor can read any round key by index, including the last round key first. It replaces the single-round combinational scheduler in the decryptor top level.

## Interface
- KEY_BITS, 128, key length; legal values 128, 192, 256. Derived: Nk = KEY_BITS/32, Nr = Nk+6, NW = 4*(Nr+1).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request expansion of key_in; sampled only in IDLE
- key_in  in  KEY_BITS  cipher key, column-major; key_in[KEY_BITS-1 -: 32] = w0
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse after the last word is written
- key_ready  out  1  full schedule valid in the array
- rk_idx  in  4  round-key index 0..Nr
- rk_out  out  128  round key rk_idx, registered; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]

## Operation
- States: IDLE and EXPAND.
- **IDLE, start=1:**
  - capture w[0..Nk-1] from key_in in one cycle;
  - set i=Nk, k=0 (i mod Nk counter), rcon=8'h01;
  - busy<=1, key_ready<=0; go to EXPAND.
- **IDLE, start=0:** hold.
- **EXPAND, each cycle:** temp = w[i-1].
  - If k==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and rcon <= xtime(rcon). xtime is shift left 1, XOR 8'h1B if bit 7 was set.
  - Else if Nk==8 and k==4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp; i++; k wraps Nk-1 to 0.
- **EXPAND exit:** when i==NW-1 is written, go to IDLE; busy<=0, done<=1 for one cycle, key_ready<=1.
- start while busy is ignored; no queueing.
- key_in is sampled only on the accepting edge; later changes have no effect.
- start in IDLE with key_ready=1 starts a new expansion and drops key_ready on the same edge.
- **Read port:**
  - rk_out <= words 4*rk_idx..4*rk_idx+3 every cycle, independent of state.
  - rk_idx > Nr gives rk_out <= 0.
  - Reads while key_ready=0 return array contents with no validity guarantee.

## Timing
- Reset values: state IDLE, busy 0, done 0, key_ready 0, rk_out 0, i=0, k=0, rcon 8'h01. The word array is not cleared.
- **Busy duration:** the accepting edge raises busy, which stays high for NW-Nk cycles: 40 (128), 46 (192), 52 (256).
- done and key_ready rise on the edge busy falls. Start-to-done latency is NW-Nk+1 edges.
- rk_out has 1-cycle latency from rk_idx.
- Reading during the done cycle returns final values, because the last write precedes the read edge.
- **Reset mid-EXPAND:**
  - return to IDLE with all outputs at reset values;
  - partial words are left in the array, and key_ready stays 0 until a full run completes.
- **Reset and start on the same edge:** reset wins.

## Structure
- Package aes_pkg holds:
  - the KEY_BITS legality check and Nk/Nr/NW derivation functions;
  - the xtime function and the initial Rcon constant;
  - the state enum (IDLE, EXPAND).
- One sub-module, aes_subword: four instances of the existing byte SBOX, with a 32-bit in/out.
  - It is used once; RotWord is a wire permutation ahead of it.
- Word array: NW x 32 registers.
  - One write port (w[i]).
  - Two read sources: w[i-1] and w[i-Nk], both as a mux on i.
  - The rk_out read port.

## Test plan
- **AES-128:** KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle -> busy high 40 cycles, done pulse; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 -> the key.
- **AES-192:** KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> busy 46 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- **AES-256:** KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> busy 52 cycles; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e. This checks the k==4 SubWord path.
- **Reverse read sweep:** after done, rk_idx 10 down to 0 on consecutive cycles -> each rk_out matches FIPS-197 one cycle later; rk_idx=15 -> 0.
- **Start while busy:** start re-asserted mid-EXPAND with a different key -> ignored; results equal the first key's schedule.
- **Reset mid-operation:** rst at cycle 20 of EXPAND -> busy/done/key_ready 0 next cycle; a new start with key 000102030405060708090a0b0c0d0e0f gives rk_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
